rename_ctrl: RTL and testbench



---
 rtl/rv32i_types.sv | 18 +
 rtl/rename_free_list.sv | 90 +++++++++
 rtl/rename_ctrl.sv | 115 +++++++++++
 tb/tb_rename_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared rename-stage types and free-list sizing helpers
package rv32i_types;

    // Free-list pointers carry one extra wrap bit to tell full from empty.
    function automatic int fl_depth(input int phys_bits, input int arch_bits);
        return (1 << phys_bits) - (1 << arch_bits);
    endfunction

    function automatic int fl_ptr(input int phys_bits, input int arch_bits);
        return $clog2(fl_depth(phys_bits, arch_bits)) + 1;
    endfunction

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } rename_state_e;

endpackage

// File: rtl/rename_free_list.sv
// rtl/rename_free_list.sv - circular physical-register free list with multi-pop, multi-push and flush restore
module rename_free_list
    import rv32i_types::*;
#(
    parameter int PHYS_BITS = 6,
    parameter int ARCH_BITS = 5,
    parameter int NSIZE     = 2,
    localparam int FL_DEPTH = fl_depth(PHYS_BITS, ARCH_BITS),
    localparam int FL_PTR   = fl_ptr(PHYS_BITS, ARCH_BITS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NSIZE-1:0]                 take,
    input  logic                             alloc,
    output logic [NSIZE-1:0][PHYS_BITS-1:0]  pop_pd,
    input  logic [NSIZE-1:0]                 push,
    input  logic [NSIZE-1:0][PHYS_BITS-1:0]  push_pd,
    input  logic                             restore,
    output logic [FL_PTR-1:0]                count
);

    localparam int IDX_W      = FL_PTR - 1;
    localparam int ARCH_COUNT = 1 << ARCH_BITS;

    logic [PHYS_BITS-1:0] mem [FL_DEPTH];
    logic [FL_PTR-1:0]    head;
    logic [FL_PTR-1:0]    tail;
    logic [FL_PTR-1:0]    rhead;
    logic [FL_PTR-1:0]    ntake;
    logic [FL_PTR-1:0]    npush;
    logic [FL_PTR-1:0]    rd_ptr;
    logic [FL_PTR-1:0]    wr_ptr;
    logic [IDX_W-1:0]     rd_idx [NSIZE];
    logic [IDX_W-1:0]     wr_idx [NSIZE];

    // Slot i reads/writes at the pointer plus the number of active earlier slots.
    always_comb begin
        ntake  = '0;
        npush  = '0;
        rd_ptr = '0;
        wr_ptr = '0;
        for (int i = 0; i < NSIZE; i++) begin
            rd_ptr    = head + ntake;
            wr_ptr    = tail + npush;
            rd_idx[i] = rd_ptr[IDX_W-1:0];
            wr_idx[i] = wr_ptr[IDX_W-1:0];
            ntake     = ntake + FL_PTR'(take[i]);
            npush     = npush + FL_PTR'(push[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < NSIZE; i++) begin
            pop_pd[i] = mem[rd_idx[i]];
        end
    end

    assign count = tail - head;

    // Restore lands on the post-commit retire head: popped-but-unretired
    // entries are still in the array and become free again.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            rhead <= '0;
            tail  <= FL_PTR'(FL_DEPTH);
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem[i] <= PHYS_BITS'(ARCH_COUNT + i);
            end
        end else begin
            for (int i = 0; i < NSIZE; i++) begin
                if (push[i]) begin
                    mem[wr_idx[i]] <= push_pd[i];
                end
            end
            tail  <= tail + npush;
            rhead <= rhead + npush;
            if (restore) begin
                head <= rhead + npush;
            end else if (alloc) begin
                head <= head + ntake;
            end
        end
    end

    free_list_overflow: assert property (@(posedge clk) disable iff (rst)
        int'(npush) <= FL_DEPTH - int'(count))
        else $error("free list overflow");

endmodule

// File: rtl/rename_ctrl.sv
// rtl/rename_ctrl.sv - rename sequencer: need computation, dispatch handshake and flush recovery FSM
module rename_ctrl
    import rv32i_types::*;
#(
    parameter int PHYS_BITS   = 6,
    parameter int ARCH_BITS   = 5,
    parameter int NSIZE       = 2,
    parameter int FLUSH_STALL = 1,
    localparam int FL_PTR     = fl_ptr(PHYS_BITS, ARCH_BITS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             dec_valid,
    output logic                             dec_ready,
    input  logic [NSIZE-1:0]                 dec_slot_valid,
    input  logic [NSIZE-1:0]                 dec_regf_we,
    input  logic [NSIZE-1:0][ARCH_BITS-1:0]  dec_rd,
    input  logic                             disp_ready,
    output logic [NSIZE-1:0]                 alias_regf_we,
    output logic [NSIZE-1:0][ARCH_BITS-1:0]  alias_rd,
    output logic [NSIZE-1:0][PHYS_BITS-1:0]  alias_pd,
    output logic                             ren_fire,
    input  logic [NSIZE-1:0]                 commit_free,
    input  logic [NSIZE-1:0][PHYS_BITS-1:0]  commit_pd_old,
    input  logic                             rob_flush,
    output logic [FL_PTR-1:0]                fl_count
);

    localparam int CNT_W = $clog2(FLUSH_STALL + 1);

    rename_state_e                 state;
    rename_state_e                 state_next;
    logic [CNT_W-1:0]              cnt;
    logic [CNT_W-1:0]              cnt_next;
    logic [NSIZE-1:0]              needs;
    logic [FL_PTR-1:0]             need;
    logic                          fire;
    logic [NSIZE-1:0][PHYS_BITS-1:0] pop_pd;

    // x0 is hardwired, so writes to it never consume a physical register.
    always_comb begin
        need = '0;
        for (int i = 0; i < NSIZE; i++) begin
            needs[i] = dec_slot_valid[i] & dec_regf_we[i] & (dec_rd[i] != '0);
            need     = need + FL_PTR'(needs[i]);
        end
    end

    assign dec_ready = !rst && (state == RUN) && disp_ready && (fl_count >= need) && !rob_flush;
    assign fire      = dec_valid & dec_ready;
    assign ren_fire  = fire;

    always_comb begin
        for (int i = 0; i < NSIZE; i++) begin
            alias_regf_we[i] = fire & needs[i];
            alias_rd[i]      = fire ? dec_rd[i] : '0;
            alias_pd[i]      = (fire & needs[i]) ? pop_pd[i] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A flush during recovery restarts the window while the alias table reloads.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RUN: begin
                if (rob_flush) begin
                    state_next = RECOVER;
                    cnt_next   = CNT_W'(FLUSH_STALL);
                end
            end
            RECOVER: begin
                if (rob_flush) begin
                    cnt_next = CNT_W'(FLUSH_STALL);
                end else if (cnt == CNT_W'(1)) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = '0;
            end
        endcase
    end

    rename_free_list #(
        .PHYS_BITS (PHYS_BITS),
        .ARCH_BITS (ARCH_BITS),
        .NSIZE     (NSIZE)
    ) u_free_list (
        .clk     (clk),
        .rst     (rst),
        .take    (needs),
        .alloc   (fire),
        .pop_pd  (pop_pd),
        .push    (commit_free),
        .push_pd (commit_pd_old),
        .restore (rob_flush),
        .count   (fl_count)
    );

endmodule

// File: tb/tb_rename_ctrl.sv
// tb/tb_rename_ctrl.sv - randomized self-checking bench for rename_ctrl against a queue-based model
module tb_rename_ctrl;

    localparam int PB = 6;
    localparam int AB = 5;
    localparam int NS = 2;
    localparam int FS = 1;
    localparam int FP = 6;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    dec_valid;
    logic                    dec_ready;
    logic [NS-1:0]           dec_slot_valid;
    logic [NS-1:0]           dec_regf_we;
    logic [NS-1:0][AB-1:0]   dec_rd;
    logic                    disp_ready;
    logic [NS-1:0]           alias_regf_we;
    logic [NS-1:0][AB-1:0]   alias_rd;
    logic [NS-1:0][PB-1:0]   alias_pd;
    logic                    ren_fire;
    logic [NS-1:0]           commit_free;
    logic [NS-1:0][PB-1:0]   commit_pd_old;
    logic                    rob_flush;
    logic [FP-1:0]           fl_count;

    rename_ctrl #(
        .PHYS_BITS   (PB),
        .ARCH_BITS   (AB),
        .NSIZE       (NS),
        .FLUSH_STALL (FS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_slot_valid (dec_slot_valid),
        .dec_regf_we    (dec_regf_we),
        .dec_rd         (dec_rd),
        .disp_ready     (disp_ready),
        .alias_regf_we  (alias_regf_we),
        .alias_rd       (alias_rd),
        .alias_pd       (alias_pd),
        .ren_fire       (ren_fire),
        .commit_free    (commit_free),
        .commit_pd_old  (commit_pd_old),
        .rob_flush      (rob_flush),
        .fl_count       (fl_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pd;
        int pd_old;
        int rd;
    } rob_t;

    int   fl[$];
    rob_t rob[$];
    int   spec_map[32];
    int   arch_map[32];
    int   stall;
    int   checks = 0;
    int   errors = 0;
    logic [NS-1:0][PB-1:0] obs_pd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        fl.delete();
        rob.delete();
        for (int i = 0; i < 32; i++) fl.push_back(32 + i);
        for (int a = 0; a < 32; a++) begin
            spec_map[a] = a;
            arch_map[a] = a;
        end
        stall = 0;
    endtask

    function automatic bit slot_needs(input int i);
        return dec_slot_valid[i] && dec_regf_we[i] && (dec_rd[i] != 0);
    endfunction

    task automatic clear_inputs();
        dec_valid      = 1'b0;
        dec_slot_valid = '0;
        dec_regf_we    = '0;
        dec_rd         = '0;
        disp_ready     = 1'b1;
        commit_free    = '0;
        commit_pd_old  = '0;
        rob_flush      = 1'b0;
    endtask

    task automatic set_group(input logic [NS-1:0] sv, input logic [NS-1:0] we, input int rd0, input int rd1);
        dec_valid         = 1'b1;
        dec_slot_valid    = sv;
        dec_regf_we       = we;
        dec_rd[0]         = AB'(rd0);
        dec_rd[1]         = AB'(rd1);
    endtask

    // Commits release the stale mappings of the oldest in-flight allocations.
    task automatic set_commit(input logic [NS-1:0] pick);
        int k = 0;
        commit_free   = '0;
        commit_pd_old = '0;
        for (int i = 0; i < NS; i++) begin
            if (pick[i] && k < rob.size()) begin
                commit_free[i]   = 1'b1;
                commit_pd_old[i] = PB'(rob[k].pd_old);
                k++;
            end
        end
    endtask

    task automatic cycle();
        int                    need;
        int                    k;
        bit                    rdy;
        bit                    fire;
        logic [NS-1:0]         we_e;
        logic [NS-1:0][AB-1:0] rd_e;
        logic [NS-1:0][PB-1:0] pd_e;
        int                    keep[$];
        rob_t                  e;
        @(negedge clk);
        need = 0;
        for (int i = 0; i < NS; i++) if (slot_needs(i)) need++;
        rdy  = !rst && !rob_flush && stall == 0 && disp_ready && fl.size() >= need;
        fire = rdy && dec_valid;
        we_e = '0;
        rd_e = '0;
        pd_e = '0;
        k    = 0;
        if (fire) begin
            for (int i = 0; i < NS; i++) begin
                rd_e[i] = dec_rd[i];
                if (slot_needs(i)) begin
                    we_e[i] = 1'b1;
                    pd_e[i] = PB'(fl[k]);
                    k++;
                end
            end
        end
        obs_pd = alias_pd;
        if (!rst) begin
            check("dec_ready", 32'(dec_ready), 32'(rdy));
            check("ren_fire", 32'(ren_fire), 32'(fire));
            check("fl_count", 32'(fl_count), 32'(fl.size()));
            check("alias_we", 32'(alias_regf_we), 32'(we_e));
            check("alias_rd", 32'(alias_rd), 32'(rd_e));
            check("alias_pd", 32'(alias_pd), 32'(pd_e));
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (fire) begin
                for (int i = 0; i < NS; i++) begin
                    if (slot_needs(i)) begin
                        e.pd     = fl.pop_front();
                        e.rd     = int'(dec_rd[i]);
                        e.pd_old = spec_map[e.rd];
                        spec_map[e.rd] = e.pd;
                        rob.push_back(e);
                    end
                end
            end
            for (int i = 0; i < NS; i++) begin
                if (commit_free[i]) begin
                    e = rob.pop_front();
                    arch_map[e.rd] = e.pd;
                    fl.push_back(int'(commit_pd_old[i]));
                end
            end
            if (rob_flush) begin
                keep.delete();
                foreach (rob[j]) keep.push_back(rob[j].pd);
                fl = {keep, fl};
                rob.delete();
                spec_map = arch_map;
                stall = FS;
            end else if (stall > 0) begin
                stall--;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        check("rst_count", 32'(fl_count), 32);
        check("rst_fire", 32'(ren_fire), 0);
        check("rst_we", 32'(alias_regf_we), 0);
        check("rst_pd", 32'(alias_pd), 0);
        @(posedge clk);
        #1;

        set_group(2'b11, 2'b11, 5, 7);
        cycle();
        check("t1_pd", 32'(obs_pd), (33 << PB) | 32);
        check("t1_count", 32'(fl_count), 30);

        set_group(2'b11, 2'b11, 0, 9);
        cycle();
        check("t2_pd", 32'(obs_pd), 34 << PB);
        check("t2_count", 32'(fl_count), 29);

        for (int g = 0; g < 14; g++) begin
            set_group(2'b11, 2'b11, 1 + g, 2 + g);
            cycle();
        end
        check("drain_count", 32'(fl_count), 1);
        set_group(2'b11, 2'b11, 3, 4);
        cycle();
        check("starve_count", 32'(fl_count), 1);
        set_commit(2'b01);
        cycle();
        clear_inputs();
        set_group(2'b11, 2'b11, 3, 4);
        cycle();
        check("refill_count", 32'(fl_count), 0);

        do_reset();
        set_group(2'b11, 2'b11, 5, 7);
        cycle();
        clear_inputs();
        set_commit(2'b01);
        cycle();
        clear_inputs();
        set_group(2'b11, 2'b11, 3, 4);
        cycle();
        clear_inputs();
        set_group(2'b11, 2'b11, 6, 8);
        set_commit(2'b01);
        rob_flush = 1'b1;
        cycle();
        check("flush_count", 32'(fl_count), 32);
        clear_inputs();
        set_group(2'b11, 2'b11, 6, 8);
        for (int s = 0; s < FS; s++) cycle();
        cycle();
        check("flush_alloc", 32'(obs_pd), (35 << PB) | 34);
        disp_ready = 1'b0;
        cycle();
        check("nodisp_count", 32'(fl_count), 30);

        clear_inputs();
        for (int n = 0; n < 3000; n++) begin
            dec_valid      = ($urandom_range(3) != 0);
            dec_slot_valid = NS'($urandom);
            dec_regf_we    = NS'($urandom);
            for (int i = 0; i < NS; i++) dec_rd[i] = AB'($urandom);
            disp_ready     = ($urandom_range(7) != 0);
            set_commit(NS'($urandom));
            rob_flush      = ($urandom_range(39) == 0);
            rst            = (n == 1500);
            cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
